// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS-subset control FSM: state codes,
// opcodes, datapath select values and the control word driven from each state.
package control_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH      = 4'd1,
        FETCH_WAIT = 4'd2,
        DECODE     = 4'd3,
        EXEC       = 4'd4,
        R_WB       = 4'd5,
        MEM_ADDR   = 4'd6,
        MEM_RD     = 4'd7,
        MEM_WB     = 4'd8,
        MEM_WR     = 4'd9,
        BRANCH     = 4'd10,
        JUMP       = 4'd11,
        ADDI_EX    = 4'd12,
        ADDI_WB    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] SRCB_REG     = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_IMM     = 3'b010;
    localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [2:0] alu_src_b;
        logic       instr_done;
    } ctrl_word_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the control FSM (master) and the multicycle datapath (slave).
interface multicycle_control_if;
    logic [5:0] opCode;
    logic       zero;
    logic       halt;
    logic       PCWriteCond;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [2:0] ALUSrcB;
    logic       illegal_op;
    logic       instr_done;
    logic [3:0] state;
    logic       pc_en;

    // zero only ever meets the control path here, in the PC load enable
    assign pc_en = PCWrite | (PCWriteCond & zero);

    modport master (
        input  opCode, halt,
        output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
               illegal_op, instr_done, state
    );

    modport slave (
        output opCode, halt, zero,
        input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
               illegal_op, instr_done, state, pc_en
    );
endinterface

// File: rtl/control_signal_rom.sv
// Combinational state-to-control-word table; unlisted outputs default to 0.
module control_signal_rom
    import control_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
            end
            FETCH_WAIT: begin
                // RAM data is valid now, so IR and PC+4 are captured here
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_ADDR, ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: state register and next-state logic;
// control lines are decoded from the registered state by control_signal_rom.
module multicycle_control
    import control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t     state_reg;
    logic       store_reg;
    ctrl_word_t ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            store_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE:       if (!bus.halt) state_reg <= FETCH;
                FETCH:      state_reg <= FETCH_WAIT;
                FETCH_WAIT: state_reg <= DECODE;
                DECODE: begin
                    // remember LW vs SW so opCode is only looked at in DECODE
                    store_reg <= (bus.opCode == OP_SW);
                    case (bus.opCode)
                        OP_RTYPE:     state_reg <= EXEC;
                        OP_LW, OP_SW: state_reg <= MEM_ADDR;
                        OP_BEQ:       state_reg <= BRANCH;
                        OP_J:         state_reg <= JUMP;
                        OP_ADDI:      state_reg <= ADDI_EX;
                        default:      state_reg <= FETCH;
                    endcase
                end
                EXEC:     state_reg <= R_WB;
                MEM_ADDR: state_reg <= store_reg ? MEM_WR : MEM_RD;
                MEM_RD:   state_reg <= MEM_WB;
                ADDI_EX:  state_reg <= ADDI_WB;
                R_WB, MEM_WB, MEM_WR, BRANCH, JUMP, ADDI_WB:
                    state_reg <= bus.halt ? IDLE : FETCH;
                default:  state_reg <= IDLE;
            endcase
        end
    end

    control_signal_rom u_rom (
        .state (state_reg),
        .ctrl  (ctrl)
    );

    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.state       = state_reg;

    // IR is stable throughout DECODE, so the flag is qualified by state only
    assign bus.illegal_op  = (state_reg == DECODE) && !op_supported(bus.opCode);

endmodule
